axi4_wb_drop_responder: RTL and testbench

//  Write-side companion of the RAB read-drop path. Handles the W and B channels between the

---
 rtl/axi4_wb_drop_responder.sv | 205 ++++++++++++++++++++
 tb/tb_axi4_wb_drop_responder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wb_drop_responder.sv
// rtl/axi4_wb_drop_responder.sv - W/B write-path responder for forwarded and dropped bursts
// Routes W by the head routing decision and merges downstream B with locally injected B.
module axi4_wb_drop_responder #(
  parameter int AXI_DATA_WIDTH   = 32,
  parameter int AXI_ID_WIDTH     = 4,
  parameter int AXI_USER_WIDTH   = 4,
  parameter int TRANS_FIFO_DEPTH = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,

  input  logic                        trans_valid,
  output logic                        trans_ready,
  input  logic                        trans_drop,
  input  logic [AXI_ID_WIDTH-1:0]     trans_id,
  input  logic                        trans_prefetch,
  input  logic                        trans_hit,

  input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic                        s_axi4_wlast,
  input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  input  logic                        s_axi4_wvalid,
  output logic                        s_axi4_wready,

  output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic                        m_axi4_wlast,
  output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
  output logic                        m_axi4_wvalid,
  input  logic                        m_axi4_wready,

  input  logic [AXI_ID_WIDTH-1:0]     m_axi4_bid,
  input  logic [1:0]                  m_axi4_bresp,
  input  logic [AXI_USER_WIDTH-1:0]   m_axi4_buser,
  input  logic                        m_axi4_bvalid,
  output logic                        m_axi4_bready,

  output logic [AXI_ID_WIDTH-1:0]     s_axi4_bid,
  output logic [1:0]                  s_axi4_bresp,
  output logic [AXI_USER_WIDTH-1:0]   s_axi4_buser,
  output logic                        s_axi4_bvalid,
  input  logic                        s_axi4_bready
);

  localparam int PW = $clog2(TRANS_FIFO_DEPTH);

  typedef struct packed {
    logic                    drop;
    logic                    prefetch;
    logic                    hit;
    logic [AXI_ID_WIDTH-1:0] id;
  } dec_t;

  typedef struct packed {
    logic                    prefetch;
    logic                    hit;
    logic [AXI_ID_WIDTH-1:0] id;
  } inj_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_FWD  = 2'd1,
    SEL_INJ  = 2'd2
  } sel_e;

  dec_t        r_dec_mem [TRANS_FIFO_DEPTH];
  logic [PW:0] r_dec_wr;
  logic [PW:0] r_dec_rd;
  inj_t        r_inj_mem [TRANS_FIFO_DEPTH];
  logic [PW:0] r_inj_wr;
  logic [PW:0] r_inj_rd;
  sel_e        r_sel;

  dec_t        w_dec_head;
  inj_t        w_inj_head;
  logic        w_dec_empty;
  logic        w_dec_full;
  logic        w_dec_push;
  logic        w_dec_pop;
  logic        w_inj_empty;
  logic        w_inj_full;
  logic        w_inj_push;
  logic        w_inj_pop;
  logic        w_w_hs;
  logic [1:0]  w_inj_resp;
  sel_e        w_sel;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_dec_empty = (r_dec_wr == r_dec_rd);
  assign w_dec_full  = (r_dec_wr[PW] != r_dec_rd[PW]) && (r_dec_wr[PW-1:0] == r_dec_rd[PW-1:0]);
  assign w_inj_empty = (r_inj_wr == r_inj_rd);
  assign w_inj_full  = (r_inj_wr[PW] != r_inj_rd[PW]) && (r_inj_wr[PW-1:0] == r_inj_rd[PW-1:0]);

  assign w_dec_head  = r_dec_mem[r_dec_rd[PW-1:0]];
  assign w_inj_head  = r_inj_mem[r_inj_rd[PW-1:0]];

  assign trans_ready = !w_dec_full;
  assign w_dec_push  = trans_valid && !w_dec_full;

  always_comb begin
    m_axi4_wdata  = s_axi4_wdata;
    m_axi4_wstrb  = s_axi4_wstrb;
    m_axi4_wlast  = s_axi4_wlast;
    m_axi4_wuser  = s_axi4_wuser;
    m_axi4_wvalid = 1'b0;
    s_axi4_wready = 1'b0;
    if (!w_dec_empty) begin
      if (!w_dec_head.drop) begin
        m_axi4_wvalid = s_axi4_wvalid;
        s_axi4_wready = m_axi4_wready;
      end else begin
        // A dropped burst may only finish when its B response has somewhere to go.
        s_axi4_wready = s_axi4_wlast ? !w_inj_full : 1'b1;
      end
    end
  end

  assign w_w_hs     = s_axi4_wvalid && s_axi4_wready;
  assign w_dec_pop  = w_w_hs && s_axi4_wlast;
  assign w_inj_push = w_dec_pop && w_dec_head.drop;

  // Prefetch drops answer like any other drop: only a TLB hit turns SLVERR into OKAY.
  always_comb begin
    w_inj_resp = 2'b10;
    case ({w_inj_head.prefetch, w_inj_head.hit})
      2'b01, 2'b11: w_inj_resp = 2'b00;
      default:      w_inj_resp = 2'b10;
    endcase
  end

  always_comb begin
    w_sel = r_sel;
    if (r_sel == SEL_NONE) begin
      if (!w_inj_empty) begin
        w_sel = SEL_INJ;
      end else if (m_axi4_bvalid) begin
        w_sel = SEL_FWD;
      end
    end
  end

  always_comb begin
    s_axi4_bvalid = 1'b0;
    s_axi4_bid    = '0;
    s_axi4_bresp  = 2'b00;
    s_axi4_buser  = '0;
    m_axi4_bready = 1'b0;
    case (w_sel)
      SEL_FWD: begin
        s_axi4_bvalid = m_axi4_bvalid;
        s_axi4_bid    = m_axi4_bid;
        s_axi4_bresp  = m_axi4_bresp;
        s_axi4_buser  = m_axi4_buser;
        m_axi4_bready = s_axi4_bready;
      end
      SEL_INJ: begin
        s_axi4_bvalid = 1'b1;
        s_axi4_bid    = w_inj_head.id;
        s_axi4_bresp  = w_inj_resp;
      end
      default: begin
      end
    endcase
  end

  assign w_inj_pop = (w_sel == SEL_INJ) && s_axi4_bready;

  always_ff @(posedge axi4_aclk) begin
    if (w_dec_push) begin
      r_dec_mem[r_dec_wr[PW-1:0]] <= {trans_drop, trans_prefetch, trans_hit, trans_id};
    end
    if (w_inj_push) begin
      r_inj_mem[r_inj_wr[PW-1:0]] <= {w_dec_head.prefetch, w_dec_head.hit, w_dec_head.id};
    end
  end

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_dec_wr <= '0;
      r_dec_rd <= '0;
      r_inj_wr <= '0;
      r_inj_rd <= '0;
    end else begin
      if (w_dec_push) r_dec_wr <= r_dec_wr + (PW+1)'(1);
      if (w_dec_pop)  r_dec_rd <= r_dec_rd + (PW+1)'(1);
      if (w_inj_push) r_inj_wr <= r_inj_wr + (PW+1)'(1);
      if (w_inj_pop)  r_inj_rd <= r_inj_rd + (PW+1)'(1);
    end
  end

  // A presented B is locked only while it stalls; an immediate handshake needs no lock.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      r_sel <= SEL_NONE;
    end else if (r_sel == SEL_NONE) begin
      if ((w_sel != SEL_NONE) && !s_axi4_bready) begin
        r_sel <= w_sel;
      end
    end else if (s_axi4_bvalid && s_axi4_bready) begin
      r_sel <= SEL_NONE;
    end
  end

endmodule

// File: tb/tb_axi4_wb_drop_responder.sv
// tb/tb_axi4_wb_drop_responder.sv - bench for axi4_wb_drop_responder
module tb_axi4_wb_drop_responder;

  localparam int NB = 40;

  logic        clk = 1'b0;
  logic        rstn;
  logic        trans_valid, trans_ready, trans_drop, trans_prefetch, trans_hit;
  logic [3:0]  trans_id;
  logic [31:0] s_axi4_wdata, m_axi4_wdata;
  logic [3:0]  s_axi4_wstrb, m_axi4_wstrb, s_axi4_wuser, m_axi4_wuser;
  logic        s_axi4_wlast, s_axi4_wvalid, s_axi4_wready;
  logic        m_axi4_wlast, m_axi4_wvalid, m_axi4_wready;
  logic [3:0]  m_axi4_bid, m_axi4_buser, s_axi4_bid, s_axi4_buser;
  logic [1:0]  m_axi4_bresp, s_axi4_bresp;
  logic        m_axi4_bvalid, m_axi4_bready, s_axi4_bvalid, s_axi4_bready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi4_wb_drop_responder dut (
    .axi4_aclk(clk), .axi4_arstn(rstn),
    .trans_valid(trans_valid), .trans_ready(trans_ready), .trans_drop(trans_drop),
    .trans_id(trans_id), .trans_prefetch(trans_prefetch), .trans_hit(trans_hit),
    .s_axi4_wdata(s_axi4_wdata), .s_axi4_wstrb(s_axi4_wstrb), .s_axi4_wlast(s_axi4_wlast),
    .s_axi4_wuser(s_axi4_wuser), .s_axi4_wvalid(s_axi4_wvalid), .s_axi4_wready(s_axi4_wready),
    .m_axi4_wdata(m_axi4_wdata), .m_axi4_wstrb(m_axi4_wstrb), .m_axi4_wlast(m_axi4_wlast),
    .m_axi4_wuser(m_axi4_wuser), .m_axi4_wvalid(m_axi4_wvalid), .m_axi4_wready(m_axi4_wready),
    .m_axi4_bid(m_axi4_bid), .m_axi4_bresp(m_axi4_bresp), .m_axi4_buser(m_axi4_buser),
    .m_axi4_bvalid(m_axi4_bvalid), .m_axi4_bready(m_axi4_bready),
    .s_axi4_bid(s_axi4_bid), .s_axi4_bresp(s_axi4_bresp), .s_axi4_buser(s_axi4_buser),
    .s_axi4_bvalid(s_axi4_bvalid), .s_axi4_bready(s_axi4_bready)
  );

  typedef struct packed {
    logic tv, td; logic [3:0] tid; logic th, tp;
    logic wv, wl, mwr, mbv; logic [3:0] mbid; logic [1:0] mbresp; logic sbr;
    logic e_tr, e_swr, e_mwv, e_sbv; logic [3:0] e_bid; logic [1:0] e_resp;
    logic [3:0] e_buser; logic e_mbr;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input int tv, td, tid, th, tp, wv, wl, mwr, mbv, mbid, mbresp, sbr,
                              input int etr, eswr, emwv, esbv, ebid, eresp, ebuser, embr);
    vec_t v;
    v.tv = 1'(tv); v.td = 1'(td); v.tid = 4'(tid); v.th = 1'(th); v.tp = 1'(tp);
    v.wv = 1'(wv); v.wl = 1'(wl); v.mwr = 1'(mwr); v.mbv = 1'(mbv);
    v.mbid = 4'(mbid); v.mbresp = 2'(mbresp); v.sbr = 1'(sbr);
    v.e_tr = 1'(etr); v.e_swr = 1'(eswr); v.e_mwv = 1'(emwv); v.e_sbv = 1'(esbv);
    v.e_bid = 4'(ebid); v.e_resp = 2'(eresp); v.e_buser = 4'(ebuser); v.e_mbr = 1'(embr);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    trans_valid = 0; trans_drop = 0; trans_id = 0; trans_prefetch = 0; trans_hit = 0;
    s_axi4_wdata = 0; s_axi4_wstrb = 0; s_axi4_wlast = 0; s_axi4_wuser = 0; s_axi4_wvalid = 0;
    m_axi4_wready = 0; m_axi4_bid = 0; m_axi4_bresp = 0; m_axi4_buser = 0; m_axi4_bvalid = 0;
    s_axi4_bready = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase state: burst descriptors and the transaction-level model.
  int          b_len [NB];
  logic        b_drop [NB], b_hit [NB], b_pf [NB];
  logic [3:0]  b_id [NB];
  logic [5:0]  mdq[$];       // {drop, hit, id} decisions in AW order
  logic [5:0]  exp_inj[$];   // {id, resp}
  logic [9:0]  exp_fwd[$];   // {id, resp, user}
  logic [9:0]  pend[$];      // downstream B queue
  logic [40:0] exp_beat[$];  // {data, strb, user, last}

  initial begin
    int dec_i, w_bi, w_beat, bdone, cyc, pre_sz;
    logic f_whs, f_wlast, f_mbhs, p_sbv, p_sbr;
    logic [9:0] p_pay, nbv;
    logic [40:0] eb;

    //                tv td id h p  wv wl mwr mbv mbid rsp sbr | tr swr mwv sbv bid rsp usr mbr
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1,  1, 0, 0, 1, 3, 0, 10, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 5, 2, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 1, 2, 0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);

    idle_in();
    rstn = 0;
    @(negedge clk);
    chk("reset trans_ready", trans_ready, 1);
    chk("reset s_wready", s_axi4_wready, 0);
    chk("reset s_bvalid", s_axi4_bvalid, 0);
    tick();
    rstn = 1;
    @(negedge clk);
    chk("post-reset trans_ready", trans_ready, 1);
    chk("post-reset m_wvalid", m_axi4_wvalid, 0);
    chk("post-reset m_bready", m_axi4_bready, 0);
    tick();

    for (int i = 0; i < 18; i++) begin
      trans_valid = tbl[i].tv; trans_drop = tbl[i].td; trans_id = tbl[i].tid;
      trans_hit = tbl[i].th; trans_prefetch = tbl[i].tp;
      s_axi4_wvalid = tbl[i].wv; s_axi4_wlast = tbl[i].wl; m_axi4_wready = tbl[i].mwr;
      s_axi4_wdata = $urandom; s_axi4_wstrb = 4'($urandom); s_axi4_wuser = 4'($urandom);
      m_axi4_bvalid = tbl[i].mbv; m_axi4_bid = tbl[i].mbid; m_axi4_bresp = tbl[i].mbresp;
      m_axi4_buser = 4'hA; s_axi4_bready = tbl[i].sbr;
      @(negedge clk);
      chk($sformatf("v%0d trans_ready", i), trans_ready, tbl[i].e_tr);
      chk($sformatf("v%0d s_wready", i), s_axi4_wready, tbl[i].e_swr);
      chk($sformatf("v%0d m_wvalid", i), m_axi4_wvalid, tbl[i].e_mwv);
      chk($sformatf("v%0d s_bvalid", i), s_axi4_bvalid, tbl[i].e_sbv);
      chk($sformatf("v%0d m_bready", i), m_axi4_bready, tbl[i].e_mbr);
      if (tbl[i].e_mwv)
        chk($sformatf("v%0d m_w payload", i), {m_axi4_wdata, m_axi4_wstrb, m_axi4_wuser, m_axi4_wlast},
            {s_axi4_wdata, s_axi4_wstrb, s_axi4_wuser, s_axi4_wlast});
      if (tbl[i].e_sbv)
        chk($sformatf("v%0d s_b payload", i), {s_axi4_bid, s_axi4_bresp, s_axi4_buser},
            {tbl[i].e_bid, tbl[i].e_resp, tbl[i].e_buser});
      tick();
    end

    // Ordering: W waits for its decision, then routes fwd/drop/fwd in AW order.
    idle_in();
    s_axi4_wvalid = 1;
    @(negedge clk); chk("t4 stall no decision", s_axi4_wready, 0); tick();
    trans_valid = 1; trans_drop = 0;
    @(negedge clk); chk("t4 stall during push", s_axi4_wready, 0); tick();
    trans_drop = 1; trans_id = 4;
    @(negedge clk); chk("t4 fwd head m_wvalid", m_axi4_wvalid, 1); tick();
    trans_drop = 0; tick();
    trans_valid = 0; m_axi4_wready = 1;
    @(negedge clk); chk("t4 A beat0 m_wvalid", m_axi4_wvalid, 1); chk("t4 A beat0 s_wready", s_axi4_wready, 1); tick();
    s_axi4_wlast = 1;
    @(negedge clk); chk("t4 A last m_wvalid", m_axi4_wvalid, 1); tick();
    @(negedge clk); chk("t4 B drop m_wvalid", m_axi4_wvalid, 0); chk("t4 B drop s_wready", s_axi4_wready, 1); tick();
    @(negedge clk); chk("t4 C fwd m_wvalid", m_axi4_wvalid, 1);
    chk("t4 inj B", {s_axi4_bvalid, s_axi4_bid, s_axi4_bresp}, {1'b1, 4'd4, 2'b10}); tick();
    s_axi4_wvalid = 0; s_axi4_bready = 1;
    @(negedge clk); chk("t4 inj B handshake", {s_axi4_bvalid, s_axi4_bid}, {1'b1, 4'd4}); tick();
    @(negedge clk); chk("t4 idle s_bvalid", s_axi4_bvalid, 0); tick();

    // B contention with stall: injected B wins and stays put, downstream B follows once.
    idle_in();
    trans_valid = 1; trans_drop = 1; trans_id = 6; tick();
    trans_valid = 0; s_axi4_wvalid = 1; s_axi4_wlast = 1;
    @(negedge clk); chk("t5 drop last s_wready", s_axi4_wready, 1); tick();
    s_axi4_wvalid = 0; m_axi4_bvalid = 1; m_axi4_bid = 9; m_axi4_bresp = 1; m_axi4_buser = 7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t5 stall%0d inj B", k), {s_axi4_bvalid, s_axi4_bid, s_axi4_bresp, s_axi4_buser},
          {1'b1, 4'd6, 2'b10, 4'd0});
      chk($sformatf("t5 stall%0d m_bready", k), m_axi4_bready, 0);
      tick();
    end
    s_axi4_bready = 1;
    @(negedge clk); chk("t5 inj handshake", {s_axi4_bvalid, s_axi4_bid, m_axi4_bready}, {1'b1, 4'd6, 1'b0}); tick();
    @(negedge clk);
    chk("t5 fwd B", {s_axi4_bvalid, s_axi4_bid, s_axi4_bresp, s_axi4_buser}, {1'b1, 4'd9, 2'b01, 4'd7});
    chk("t5 fwd m_bready", m_axi4_bready, 1); tick();
    m_axi4_bvalid = 0;
    @(negedge clk); chk("t5 delivered once", s_axi4_bvalid, 0); tick();

    // Full decision FIFO, ignored fifth push, then reset mid-burst.
    idle_in();
    for (int k = 0; k < 4; k++) begin
      trans_valid = 1;
      @(negedge clk); chk($sformatf("t6 ready push%0d", k), trans_ready, 1); tick();
    end
    @(negedge clk); chk("t6 full", trans_ready, 0); tick();
    trans_valid = 0; s_axi4_wvalid = 1; s_axi4_wlast = 1; m_axi4_wready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk($sformatf("t6 drain%0d m_wvalid", k), m_axi4_wvalid, 1); tick();
    end
    @(negedge clk); chk("t6 fifth ignored", s_axi4_wready, 0); tick();
    s_axi4_wvalid = 0; trans_valid = 1; trans_drop = 1; trans_id = 1; tick();
    trans_id = 7; s_axi4_wvalid = 1;
    @(negedge clk); chk("t6 drop last", s_axi4_wready, 1); tick();
    trans_valid = 0; s_axi4_wlast = 0;
    @(negedge clk); chk("t6 inj pending", s_axi4_bvalid, 1); tick();
    rstn = 0;
    @(negedge clk);
    chk("t6 in reset", {s_axi4_wready, m_axi4_wvalid, s_axi4_bvalid, m_axi4_bready, trans_ready}, 5'b00001);
    tick();
    rstn = 1; s_axi4_wlast = 1;
    @(negedge clk);
    chk("t6 after reset", {s_axi4_wready, m_axi4_wvalid, s_axi4_bvalid, trans_ready}, 4'b0001);
    tick();

    // Randomized bursts against a queue-level model.
    idle_in();
    for (int i = 0; i < NB; i++) begin
      b_len[i] = $urandom_range(1, 4); b_drop[i] = ($urandom_range(0, 2) == 0);
      b_id[i] = 4'($urandom); b_hit[i] = 1'($urandom); b_pf[i] = 1'($urandom);
    end
    dec_i = 0; w_bi = 0; w_beat = 0; bdone = 0; cyc = 0;
    f_whs = 0; f_wlast = 0; f_mbhs = 0; p_sbv = 0; p_sbr = 0; p_pay = 0;
    while (bdone < NB && cyc < 6000) begin
      if (f_whs) begin
        s_axi4_wvalid = 0;
        if (f_wlast) begin w_bi++; w_beat = 0; end else w_beat++;
      end
      if (f_mbhs) m_axi4_bvalid = 0;
      trans_valid = (dec_i < NB) && ($urandom_range(0, 1) == 1);
      if (dec_i < NB) begin
        trans_drop = b_drop[dec_i]; trans_id = b_id[dec_i];
        trans_hit = b_hit[dec_i]; trans_prefetch = b_pf[dec_i];
      end
      if (!s_axi4_wvalid && w_bi < NB && $urandom_range(0, 2) != 0) begin
        s_axi4_wvalid = 1; s_axi4_wdata = $urandom; s_axi4_wstrb = 4'($urandom);
        s_axi4_wuser = 4'($urandom); s_axi4_wlast = (w_beat == b_len[w_bi] - 1);
      end
      m_axi4_wready = ($urandom_range(0, 3) != 0);
      if (!m_axi4_bvalid && pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        m_axi4_bvalid = 1;
        {m_axi4_bid, m_axi4_bresp, m_axi4_buser} = pend[0];
      end
      s_axi4_bready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      pre_sz = mdq.size();
      chk("rnd trans_ready", trans_ready, pre_sz < 4);
      if (s_axi4_wvalid) begin
        if (pre_sz == 0) chk("rnd w stall", s_axi4_wready, 0);
        else if (mdq[0][5]) chk("rnd drop m_wvalid", m_axi4_wvalid, 0);
        else chk("rnd fwd m_wvalid", m_axi4_wvalid, 1);
      end
      if (p_sbv && !p_sbr)
        chk("rnd b held", {s_axi4_bvalid, s_axi4_bid, s_axi4_bresp, s_axi4_buser}, {1'b1, p_pay});
      if (s_axi4_bvalid && s_axi4_buser == 0) chk("rnd m_bready under inj", m_axi4_bready, 0);
      f_whs = s_axi4_wvalid && s_axi4_wready;
      f_wlast = s_axi4_wlast;
      f_mbhs = m_axi4_bvalid && m_axi4_bready;
      if (f_whs && pre_sz > 0) begin
        if (!mdq[0][5]) exp_beat.push_back({s_axi4_wdata, s_axi4_wstrb, s_axi4_wuser, s_axi4_wlast});
        if (s_axi4_wlast) begin
          if (mdq[0][5]) exp_inj.push_back({mdq[0][3:0], (mdq[0][4] ? 2'b00 : 2'b10)});
          void'(mdq.pop_front());
        end
      end
      if (m_axi4_wvalid && m_axi4_wready) begin
        if (exp_beat.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rnd unexpected m beat: got data %0h expected none", m_axi4_wdata);
        end else begin
          eb = exp_beat.pop_front();
          chk("rnd m beat", {m_axi4_wdata, m_axi4_wstrb, m_axi4_wuser, m_axi4_wlast}, eb);
          if (m_axi4_wlast) begin
            nbv = {4'($urandom), 2'($urandom), 4'($urandom_range(1, 15))};
            pend.push_back(nbv); exp_fwd.push_back(nbv);
          end
        end
      end
      if (f_mbhs) void'(pend.pop_front());
      if (s_axi4_bvalid && s_axi4_bready) begin
        bdone++;
        if (s_axi4_buser == 0) begin
          if (exp_inj.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rnd unexpected inj B: got id %0h expected none", s_axi4_bid);
          end else chk("rnd inj B", {s_axi4_bid, s_axi4_bresp}, exp_inj.pop_front());
        end else begin
          if (exp_fwd.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL rnd unexpected fwd B: got id %0h expected none", s_axi4_bid);
          end else chk("rnd fwd B", {s_axi4_bid, s_axi4_bresp, s_axi4_buser}, exp_fwd.pop_front());
        end
      end
      if (trans_valid && pre_sz < 4) begin
        mdq.push_back({trans_drop, trans_hit, trans_id});
        dec_i++;
      end
      p_sbv = s_axi4_bvalid; p_sbr = s_axi4_bready;
      p_pay = {s_axi4_bid, s_axi4_bresp, s_axi4_buser};
      tick();
      cyc++;
    end
    chk("rnd all B delivered", bdone, NB);
    chk("rnd leftover expected B", exp_inj.size() + exp_fwd.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
